// File: rtl/soc_pkg.sv
// Shared constants, UART state encoding and ASCII helpers for the soc
// line-calculator.
package soc_pkg;

  localparam int CLKS_PER_BIT_DEF = 218;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_QM   = 8'h3F;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A    = 8'h41;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return ASCII_ZERO + {4'd0, nib};
    else             return ASCII_A + {4'd0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/soc_if.sv
// soc_if carries received bytes from the UART receiver to the core;
// soc_pins_if bundles the external pins for whoever drives/observes them.
interface soc_if;
  logic       valid;
  logic [7:0] data;
  modport master (output valid, output data);
  modport slave  (input  valid, input  data);
endinterface

interface soc_pins_if;
  logic       RXD;
  logic       TXD;
  logic [4:0] LEDS;
  modport dut (input  RXD, output TXD, output LEDS);
  modport tb  (output RXD, input  TXD, input  LEDS);
endinterface

// File: rtl/soc_uart_rx.sv
// 8N1 UART receiver: synchronised input, mid-bit sampling, framing check,
// one-cycle valid pulse per good byte.
module soc_uart_rx
  import soc_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  rxd_i,
  soc_if.master rx_o
);

  localparam int             CW   = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic          sync1_q, sync2_q, prev_q;
  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
    end else begin
      sync1_q <= rxd_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) state_d = START;
      end
      START: begin
        // Half-bit recheck rejects glitches and aligns sampling to mid-bit.
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          valid_d = sync2_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_o.valid = valid_q;
  assign rx_o.data  = shift_q;

endmodule

// File: rtl/soc.sv
// Line calculator: decimal digits + CR drive LEDS and a hex echo over UART;
// contains the line parser, response buffer/sequencer and UART transmitter.
module soc
  import soc_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       RXD,
  output logic       TXD,
  output logic [4:0] LEDS
);

  localparam int             CW   = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  soc_if rx_bus ();

  soc_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk   (clk),
    .rst_n (resetn),
    .rxd_i (RXD),
    .rx_o  (rx_bus)
  );

  logic [15:0]   acc_q, acc_d;
  logic [2:0]    ndig_q, ndig_d;
  logic          err_q, err_d;
  logic [4:0]    leds_q, leds_d;
  logic [7:0]    resp_q [6];
  logic [7:0]    resp_d [6];
  logic [2:0]    len_q, len_d;
  logic [2:0]    idx_q, idx_d;
  logic [2:0]    idx_nxt;
  logic          busy_q, busy_d;
  uart_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q      <= '0;
      ndig_q     <= '0;
      err_q      <= 1'b0;
      leds_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      acc_q      <= acc_d;
      ndig_q     <= ndig_d;
      err_q      <= err_d;
      leds_q     <= leds_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  // Response payload is only read while busy_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    resp_q <= resp_d;
  end

  assign idx_nxt = idx_q + 3'd1;

  always_comb begin
    acc_d      = acc_q;
    ndig_d     = ndig_q;
    err_d      = err_q;
    leds_d     = leds_q;
    resp_d     = resp_q;
    len_d      = len_q;
    idx_d      = idx_q;
    busy_d     = busy_q;
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;

    if (rx_bus.valid) begin
      if (rx_bus.data >= 8'h30 && rx_bus.data <= 8'h39) begin
        acc_d = acc_q * 16'd10 + {12'd0, rx_bus.data[3:0]};
        if (ndig_q != 3'd5) ndig_d = ndig_q + 3'd1;
      end else if (rx_bus.data == ASCII_CR) begin
        // LEDS follow every good line; a reply is only queued when TX is free.
        if (err_q) begin
          if (!busy_q) begin
            resp_d[0] = ASCII_QM;
            resp_d[1] = ASCII_CR;
            resp_d[2] = ASCII_LF;
            len_d     = 3'd3;
            idx_d     = '0;
            busy_d    = 1'b1;
          end
        end else if (ndig_q != 3'd0) begin
          leds_d = acc_q[4:0];
          if (!busy_q) begin
            resp_d[0] = hex_ascii(acc_q[15:12]);
            resp_d[1] = hex_ascii(acc_q[11:8]);
            resp_d[2] = hex_ascii(acc_q[7:4]);
            resp_d[3] = hex_ascii(acc_q[3:0]);
            resp_d[4] = ASCII_CR;
            resp_d[5] = ASCII_LF;
            len_d     = 3'd6;
            idx_d     = '0;
            busy_d    = 1'b1;
          end
        end
        acc_d  = '0;
        ndig_d = '0;
        err_d  = 1'b0;
      end else if (rx_bus.data != ASCII_LF) begin
        err_d = 1'b1;
      end
    end

    case (tx_state_q)
      IDLE: begin
        tx_cnt_d = '0;
        if (busy_q) begin
          tx_state_d = START;
          tx_shift_d = resp_q[idx_q];
        end
      end
      START: begin
        if (tx_cnt_q == FULL) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = DATA;
        end
      end
      DATA: begin
        if (tx_cnt_q == FULL) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = STOP;
        end
      end
      STOP: begin
        // Chain straight into the next start bit to keep bytes back-to-back.
        if (tx_cnt_q == FULL) begin
          tx_cnt_d = '0;
          if (idx_nxt < len_q) begin
            idx_d      = idx_nxt;
            tx_shift_d = resp_q[idx_nxt];
            tx_state_d = START;
          end else begin
            idx_d      = '0;
            busy_d     = 1'b0;
            tx_state_d = IDLE;
          end
        end
      end
      default: tx_state_d = IDLE;
    endcase
  end

  always_comb begin
    case (tx_state_q)
      START:   TXD = 1'b0;
      DATA:    TXD = tx_shift_q[0];
      default: TXD = 1'b1;
    endcase
  end

  assign LEDS = leds_q;

endmodule

// File: tb/tb_soc.sv
// Directed bench for soc: drives UART lines on RXD, decodes TXD into a
// received-byte queue and compares it against expected replies.
module tb_soc;

  localparam int CPB = 24;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  soc_pins_if pins ();

  soc #(.CLKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .resetn (resetn),
    .RXD    (pins.RXD),
    .TXD    (pins.TXD),
    .LEDS   (pins.LEDS)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int rst_cnt = 0;
  logic [7:0] exp_q [$];
  logic [8:0] got_q [$];

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout, need $finish before 80000 cycles");
    $fatal(1, "watchdog");
  end

  // TX decoder; bit 8 of each entry flags a bad start or stop bit.
  always begin : tx_mon
    logic [7:0] b;
    logic       fr;
    int         r0;
    @(negedge pins.TXD);
    r0 = rst_cnt;
    repeat (CPB / 2) @(posedge clk);
    #1;
    fr = (pins.TXD !== 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk);
      #1;
      b[i] = pins.TXD;
    end
    repeat (CPB) @(posedge clk);
    #1;
    if (pins.TXD !== 1'b1) fr = 1'b1;
    if (r0 == rst_cnt && resetn === 1'b1) got_q.push_back({fr, b});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h, need %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    pins.RXD = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      pins.RXD = b[i];
      tick(CPB);
    end
    pins.RXD = stop;
    tick(CPB);
    pins.RXD = 1'b1;
    if (!stop) tick(CPB);
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    send_byte(8'h0D, 1'b1);
  endtask

  task automatic expect_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic drain(input string tag);
    int         budget;
    logic [7:0] e;
    logic [8:0] g;
    budget = 20000;
    while (got_q.size() < exp_q.size() && budget > 0) begin
      tick(1);
      budget--;
    end
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 9'h1FF;
      check({tag, "_byte"}, 32'(g), 32'({1'b0, e}));
    end
    tick(3 * CPB);
    check({tag, "_extra"}, 32'(got_q.size()), 32'd0);
  endtask

  initial begin
    int k;
    int lows;
    resetn   = 1'b0;
    pins.RXD = 1'b1;
    tick(5);
    check("rst_txd", 32'(pins.TXD), 32'd1);
    check("rst_leds", 32'(pins.LEDS), 32'd0);
    resetn = 1'b1;
    tick(5);

    expect_str("0242");
    send_line("578");
    drain("l578");
    check("leds_578", 32'(pins.LEDS), 32'b00010);

    expect_str("000E");
    send_line("14");
    drain("l14");
    check("leds_14", 32'(pins.LEDS), 32'b01110);

    exp_q.push_back(8'h3F);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    send_line("A");
    drain("lerr");
    check("leds_err", 32'(pins.LEDS), 32'b01110);

    expect_str("0003");
    send_line("3");
    check("leds_3", 32'(pins.LEDS), 32'b00011);
    send_line("9");
    check("leds_9_busy", 32'(pins.LEDS), 32'b01001);
    drain("l3");

    expect_str("1170");
    send_line("70000");
    drain("l70000");
    check("leds_wrap", 32'(pins.LEDS), 32'b10000);

    send_byte(8'h35, 1'b0);
    send_byte(8'h0D, 1'b1);
    tick(1000);
    check("frame_no_resp", 32'(got_q.size()), 32'd0);
    check("frame_leds", 32'(pins.LEDS), 32'b10000);

    send_line("578");
    k = 0;
    while (pins.TXD !== 1'b0 && k < 5000) begin
      tick(1);
      k++;
    end
    check("tx_started", 32'(pins.TXD), 32'd0);
    check("leds_pre_rst", 32'(pins.LEDS), 32'b00010);
    tick(100);
    rst_cnt++;
    resetn = 1'b0;
    #1;
    check("midrst_txd", 32'(pins.TXD), 32'd1);
    check("midrst_leds", 32'(pins.LEDS), 32'd0);
    tick(10);
    resetn = 1'b1;
    lows = 0;
    for (int i = 0; i < 30 * CPB; i++) begin
      tick(1);
      if (pins.TXD !== 1'b1) lows++;
    end
    check("post_rst_quiet", 32'(lows), 32'd0);
    got_q.delete();

    expect_str("0007");
    send_line("7");
    drain("l7");
    check("leds_7", 32'(pins.LEDS), 32'b00111);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/soc.md
SOC -- requirements
Module: soc

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 218, the number of clk cycles per UART bit.
REQ-002 Port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-003 Port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port RXD, input, 1 bit: UART receive line, 8N1, LSB first, idle high.
REQ-005 Port TXD, output, 1 bit: UART transmit line, 8N1, LSB first, idle high.
REQ-006 Port LEDS, output, 5 bits: low 5 bits of the last accepted line value.

Function
REQ-007 RXD SHALL pass through a 2-flop synchronizer before any use.
REQ-008 RX start detection: a falling edge while the receiver is idle SHALL start a frame; the line SHALL be re-checked at CLKS_PER_BIT/2; if high, return to idle (glitch).
REQ-009 RX data bits SHALL be sampled every CLKS_PER_BIT cycles from the start-bit midpoint; the stop bit SHALL be sampled likewise.
REQ-010 A stop bit sampled as 0 SHALL discard the byte (framing error); no state change.
REQ-011 A valid byte SHALL raise an internal 1-cycle rx_valid pulse together with rx_data[7:0].
REQ-012 Line parser state: acc[15:0], ndigits (saturating, 0..5 or more), err flag.
REQ-013 Byte 0x30-0x39: acc <= acc*10 + (byte-0x30), truncated mod 2^16 on wrap; ndigits increments.
REQ-014 Byte 0x0D (CR): end of line, handled per REQ-015..017; then acc, ndigits and err SHALL clear.
REQ-015 CR with err=0 and ndigits>0: LEDS <= acc[4:0]; queue the response of 4 uppercase hex ASCII digits of acc, MSB first, followed by 0x0D 0x0A (6 bytes).
REQ-016 CR with err=1: LEDS unchanged; queue the response 0x3F 0x0D 0x0A ("?" CR LF).
REQ-017 CR with ndigits=0 and err=0: ignored; no response, LEDS unchanged.
REQ-018 Byte 0x0A SHALL be ignored; any other byte SHALL set err=1.
REQ-019 TX: start bit 0, 8 data bits LSB first, stop bit 1, each bit exactly CLKS_PER_BIT cycles; bytes of a response SHALL be sent back-to-back.
REQ-020 A CR that completes while a response is still transmitting SHALL still update LEDS; its response SHALL be dropped, and the current response SHALL finish unaltered.
REQ-021 RX SHALL operate independently of TX; full duplex, no byte loss while transmitting.

Reset
REQ-022 While resetn=0: LEDS=5'b00000, TXD=1, RX and TX idle, acc=0, ndigits=0, err=0, no response pending.
REQ-023 Reset asserted mid-frame SHALL abort RX/TX immediately; after release, TXD SHALL stay high until a new response is queued.

Structure
REQ-024 A shared package SHALL hold the ASCII constants (CR 0x0D, LF 0x0A, '?' 0x3F, '0' 0x30, 'A' 0x41), the RX/TX state enums (IDLE, START, DATA, STOP) and the default CLKS_PER_BIT.
REQ-025 The UART receiver SHALL be one sub-module, soc_uart_rx; the transmitter, parser and response sequencer SHALL live in soc.

Verification
REQ-026 Reset, then send "578" CR at 218 clk/bit -> LEDS=00010; TXD carries "0242" CR LF.
REQ-027 Then send "14" CR -> LEDS=01110; TXD carries "000E" CR LF.
REQ-028 Then send "A" CR -> LEDS stays 01110; TXD carries "?" CR LF.
REQ-029 Then send "3" CR -> LEDS=00011; TXD carries "0003" CR LF.
REQ-030 Send "70000" CR (wraps to 4464) -> LEDS=10000; TXD carries "1170" CR LF. Send a byte with stop bit 0 -> byte ignored.
REQ-031 Assert resetn low mid-response -> TXD=1 and LEDS=0 immediately; send "7" CR -> LEDS=00111; TXD carries "0007" CR LF.
